// File: rtl/sponge_ctrl.sv
// SHAKE sponge sequencer: padding, block absorb, permutation and squeeze.
// Optional perm_count counter is built only when SPONGE_CTRL_PERF_EN is defined.
module sponge_ctrl #(
  parameter int RATE_BITS = 1088
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          out_words,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  input  logic [63:0]          msg_data,
  input  logic                 msg_last,
  input  logic [3:0]           msg_bytes,
  input  logic                 abs_ready,
  input  logic                 abs_full,
  output logic                 abs_valid,
  output logic [63:0]          abs_data,
  output logic                 perm_start,
  input  logic                 perm_done,
  input  logic [RATE_BITS-1:0] rate_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          perm_count
);

  localparam int WORDS = RATE_BITS / 64;
  localparam int WW = $clog2(WORDS + 1);
  localparam logic [WW-1:0] WMAX = WW'(WORDS);
  localparam logic [WW-1:0] WLAST = WW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_PAD, S_WAIT_FULL,
    S_PERM_A, S_SQUEEZE, S_PERM_S, S_DONE
  } state_t;

  state_t state, state_n;
  logic [WW-1:0] wcnt, sidx;
  logic [15:0] ocnt, owords;
  logic final_seen, pad_owed;
  logic abs_v;
  logic [63:0] abs_d, pad_w;
  logic accept, xfer, last_block;
  logic [63:0] rate_w [WORDS];

  for (genvar g = 0; g < WORDS; g++) begin : g_rate
    assign rate_w[g] = rate_out[g*64 +: 64];
  end

  function automatic logic [63:0] pad_final(
    input logic [63:0] d,
    input logic [3:0]  nb,
    input logic        lastw
  );
    logic [63:0] r;
    r = d;
    if (nb < 4'd8) begin
      for (int k = 0; k < 8; k++) begin
        if (k == int'(nb)) r[8*k +: 8] = 8'h1F;
        else if (k > int'(nb)) r[8*k +: 8] = 8'h00;
      end
      if (lastw) r[63:56] = r[63:56] | 8'h80;
    end
    return r;
  endfunction

  assign msg_ready = (state == S_ABSORB) & abs_ready
                   & (wcnt < WMAX) & ~final_seen;
  assign accept = msg_valid & msg_ready;
  assign out_valid = (state == S_SQUEEZE);
  assign out_last = out_valid & (ocnt == owords - 16'd1);
  assign out_data = out_valid ? rate_w[sidx] : '0;
  assign xfer = out_valid & out_ready;
  assign abs_valid = abs_v;
  assign abs_data = abs_v ? abs_d : '0;
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign last_block = final_seen & ~pad_owed;
  assign pad_w = (pad_owed ? 64'h1F : 64'h0)
               | ((wcnt == WLAST) ? 64'h8000_0000_0000_0000 : 64'h0);
  assign perm_start = ((state == S_WAIT_FULL) & abs_full & ~abs_v)
                    | (xfer & ~out_last & (sidx == WLAST));

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_ABSORB;
      S_ABSORB: begin
        if (wcnt == WMAX) state_n = S_WAIT_FULL;
        else if (final_seen) state_n = S_PAD;
      end
      S_PAD: if (wcnt == WMAX) state_n = S_WAIT_FULL;
      S_WAIT_FULL: if (abs_full & ~abs_v) state_n = S_PERM_A;
      S_PERM_A: begin
        if (perm_done) begin
          if (!last_block) state_n = S_ABSORB;
          else if (owords == 16'd0) state_n = S_DONE;
          else state_n = S_SQUEEZE;
        end
      end
      S_SQUEEZE: begin
        if (xfer) begin
          if (out_last) state_n = S_DONE;
          else if (sidx == WLAST) state_n = S_PERM_S;
        end
      end
      S_PERM_S: if (perm_done) state_n = S_SQUEEZE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      wcnt <= '0;
      sidx <= '0;
      ocnt <= '0;
      owords <= '0;
      final_seen <= 1'b0;
      pad_owed <= 1'b0;
      abs_v <= 1'b0;
      abs_d <= '0;
    end else begin
      state <= state_n;
      abs_v <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            owords <= out_words;
            wcnt <= '0;
            sidx <= '0;
            ocnt <= '0;
            final_seen <= 1'b0;
            pad_owed <= 1'b0;
          end
        end
        S_ABSORB: begin
          if (accept) begin
            abs_v <= 1'b1;
            abs_d <= msg_last
                   ? pad_final(msg_data, msg_bytes, wcnt == WLAST)
                   : msg_data;
            wcnt <= wcnt + WW'(1);
            if (msg_last) begin
              final_seen <= 1'b1;
              pad_owed <= (msg_bytes >= 4'd8);
            end
          end
        end
        S_PAD: begin
          if (wcnt != WMAX && abs_ready) begin
            abs_v <= 1'b1;
            abs_d <= pad_w;
            wcnt <= wcnt + WW'(1);
            pad_owed <= 1'b0;
          end
        end
        S_PERM_A: if (perm_done && !last_block) wcnt <= '0;
        S_SQUEEZE: begin
          if (xfer) begin
            ocnt <= ocnt + 16'd1;
            sidx <= (sidx == WLAST) ? '0 : sidx + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPONGE_CTRL_PERF_EN
  logic [15:0] pcnt;
  always_ff @(posedge clk) begin
    if (!reset_n) pcnt <= '0;
    else if (state == S_IDLE && start) pcnt <= '0;
    else if (perm_start && pcnt != 16'hFFFF) pcnt <= pcnt + 16'd1;
  end
  assign perm_count = pcnt;
`else
  assign perm_count = '0;
`endif

endmodule

// File: tb/tb_sponge_ctrl.sv
// Scoreboard bench for sponge_ctrl with behavioural absorb and permutation units.
module tb_sponge_ctrl;
  localparam int RB = 1088;
  localparam int WORDS = 17;
  localparam logic [63:0] TOP80 = 64'h8000_0000_0000_0000;

  logic clk, reset_n, start;
  logic [15:0] out_words;
  logic msg_valid, msg_ready, msg_last;
  logic [63:0] msg_data;
  logic [3:0] msg_bytes;
  logic abs_ready, abs_full, abs_valid;
  logic [63:0] abs_data;
  logic perm_start, perm_done;
  logic [RB-1:0] rate_out;
  logic out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic busy, done;
  logic [15:0] perm_count;

  sponge_ctrl #(.RATE_BITS(RB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .out_words(out_words),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_bytes(msg_bytes), .abs_ready(abs_ready),
    .abs_full(abs_full), .abs_valid(abs_valid), .abs_data(abs_data),
    .perm_start(perm_start), .perm_done(perm_done), .rate_out(rate_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .perm_count(perm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail = 0;
  logic [63:0] exp_abs[$];
  logic [64:0] exp_out[$];

  int acnt;
  int pc;
  int cd;

  assign abs_full = (acnt >= WORDS);

  always @(posedge clk) begin
    if (!reset_n || perm_start) acnt <= 0;
    else if (abs_valid) acnt <= acnt + 1;
  end

  // permutation unit: done 3 cycles after start, rate words tagged by perm number
  always @(posedge clk) begin
    perm_done <= 1'b0;
    if (!reset_n) begin
      cd <= 0;
    end else if (start && !busy) begin
      pc <= 0;
    end else if (perm_start) begin
      pc <= pc + 1;
      cd <= 3;
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        perm_done <= 1'b1;
        for (int i = 0; i < WORDS; i++)
          rate_out[i*64 +: 64] <= {16'(pc), 16'hC0DE, 32'(i)};
      end
    end
  end

  task automatic check(input string name, input logic [64:0] got,
                       input logic [64:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && abs_valid) begin
      if (exp_abs.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL abs_extra got=%h exp=none", abs_data);
      end else begin
        check("abs_word", {1'b0, abs_data}, {1'b0, exp_abs.pop_front()});
      end
    end
    if (reset_n && out_valid && out_ready) begin
      if (exp_out.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL out_extra got=%h exp=none", out_data);
      end else begin
        check("out_word", {out_last, out_data}, exp_out.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] msgw(input int i);
    return {32'hA500_0000 | 32'(i), 32'h3C00_0000 | 32'(i)};
  endfunction

  task automatic push_pad(input int from, input logic owed);
    logic [63:0] w;
    for (int i = from; i < WORDS; i++) begin
      w = (owed && i == from) ? 64'h1F : 64'h0;
      if (i == WORDS - 1) w = w | TOP80;
      exp_abs.push_back(w);
    end
  endtask

  task automatic push_out(input int k, input int i, input logic last);
    exp_out.push_back({last, 16'(k), 16'hC0DE, 32'(i)});
  endtask

  task automatic start_hash(input int n);
    start = 1'b1;
    out_words = 16'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d, input logic last,
                           input logic [3:0] nb);
    bit ok;
    ok = 0;
    msg_valid = 1'b1; msg_data = d; msg_last = last; msg_bytes = nb;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (msg_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      ntests++; nfail++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    tick();
    msg_valid = 1'b0; msg_last = 1'b0;
  endtask

  task automatic wait_out_valid();
    bit ok;
    ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      ntests++; nfail++;
      $display("FAIL out_valid_timeout got=0 exp=1");
    end
  endtask

  task automatic finish_test(input int nperm);
    bit ok;
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) begin
      ntests++; nfail++;
      $display("FAIL done_timeout got=0 exp=1");
    end
    check("abs_left", 65'(exp_abs.size()), 65'd0);
    check("out_left", 65'(exp_out.size()), 65'd0);
    check("perm_num", 65'(pc), 65'(nperm));
    exp_abs.delete();
    exp_out.delete();
    tick();
  endtask

  task automatic run_empty();
    exp_abs.push_back(64'h1F);
    push_pad(1, 1'b0);
    push_out(1, 0, 1'b1);
    start_hash(1);
    send_word(64'hDEAD_BEEF_0BAD_F00D, 1'b1, 4'd0);
    finish_test(1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 65'(busy), 65'd0);
    check({tag, "_flags"},
          65'({msg_ready, abs_valid, perm_start, out_valid, out_last, done}),
          65'd0);
    check({tag, "_data"}, {1'b0, abs_data | out_data}, 65'd0);
    check({tag, "_pcount"}, 65'(perm_count), 65'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; out_words = '0;
    msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; msg_bytes = '0;
    abs_ready = 1'b1; out_ready = 1'b1; rate_out = '0;
    pc = 0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // empty message
    run_empty();

    // one full block with bytes=8, padding fills the entire second block
    for (int i = 0; i < WORDS; i++) exp_abs.push_back(msgw(i));
    push_pad(0, 1'b1);
    push_out(2, 0, 1'b0);
    push_out(2, 1, 1'b1);
    start_hash(2);
    for (int i = 0; i < WORDS; i++)
      send_word(msgw(i), i == WORDS - 1, 4'd8);
    finish_test(2);

    // 7-byte final word in last slot gets 0x9F in byte 7
    for (int i = 0; i < WORDS - 1; i++) exp_abs.push_back(msgw(i));
    exp_abs.push_back(64'h9F22_3344_5566_7788);
    push_out(1, 0, 1'b1);
    start_hash(1);
    for (int i = 0; i < WORDS - 1; i++) send_word(msgw(i), 1'b0, 4'd0);
    send_word(64'h1122_3344_5566_7788, 1'b1, 4'd7);
    finish_test(1);

    // 20 output words across two squeeze blocks, with output stall
    exp_abs.push_back(64'h0000_0000_1FFF_0011);
    push_pad(1, 1'b0);
    for (int j = 0; j < 20; j++)
      push_out(j < WORDS ? 1 : 2, j % WORDS, j == 19);
    out_ready = 1'b0;
    start_hash(20);
    send_word(64'hAABB_CCDD_EEFF_0011, 1'b1, 4'd3);
    wait_out_valid();
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("hold_data", {out_last, out_data}, exp_out[0]);
    end
    tick();
    out_ready = 1'b1;
    finish_test(2);
`ifdef SPONGE_CTRL_PERF_EN
    check("perm_count", 65'(perm_count), 65'd2);
`else
    check("perm_count", 65'(perm_count), 65'd0);
`endif

    // absorb stall mid-block, start while busy ignored
    for (int i = 0; i < 5; i++) exp_abs.push_back(msgw(i + 40));
    push_pad(5, 1'b1);
    push_out(1, 0, 1'b1);
    start_hash(1);
    send_word(msgw(40), 1'b0, 4'd0);
    send_word(msgw(41), 1'b0, 4'd0);
    abs_ready = 1'b0;
    msg_valid = 1'b1; msg_data = msgw(42);
    tick();
    tick();
    @(negedge clk);
    check("stall_ready", 65'(msg_ready), 65'd0);
    check("stall_absv", 65'(abs_valid), 65'd0);
    tick();
    start_hash(7);
    abs_ready = 1'b1;
    send_word(msgw(42), 1'b0, 4'd0);
    send_word(msgw(43), 1'b0, 4'd0);
    send_word(msgw(44), 1'b1, 4'd8);
    finish_test(1);

    // reset in the middle of squeeze, then a fresh hash
    exp_abs.push_back(64'h1F);
    push_pad(1, 1'b0);
    out_ready = 1'b0;
    start_hash(20);
    send_word(64'h0, 1'b1, 4'd0);
    wait_out_valid();
    check("sq_valid", 65'(out_valid), 65'd1);
    tick();
    reset_n = 1'b0;
    tick();
    check_idle_outputs("midrst");
    reset_n = 1'b1;
    out_ready = 1'b1;
    exp_abs.delete();
    exp_out.delete();
    tick();
    run_empty();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
